// File: rtl/io_bus_bridge.sv
// io_bus_bridge
// Turns one IO task (address, direction, width, right-aligned write data) into
// a single dword-aligned peripheral bus transaction. It returns right-aligned,
// width-masked read data, or an error for misalignment, bus error or timeout.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   task_valid/address/rw_ctrl/width_ctr/write_bus : task request side
//   read_bus/task_ready/task_error                 : task completion side
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb    : bus request (registered)
//   bus_ack/bus_rdata/bus_err                      : bus response
module io_bus_bridge #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        task_valid,
  input  logic [39:0] address,
  input  logic        rw_ctrl,
  input  logic [1:0]  width_ctr,
  input  logic [63:0] write_bus,
  output logic [63:0] read_bus,
  output logic        task_ready,
  output logic        task_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [39:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  // Byte-lane mask for an access width, before shifting into position.
  function automatic logic [7:0] strb_mask(input logic [1:0] w);
    case (w)
      2'd0:    strb_mask = 8'h01;
      2'd1:    strb_mask = 8'h03;
      2'd2:    strb_mask = 8'h0F;
      2'd3:    strb_mask = 8'hFF;
      default: strb_mask = 8'hFF;
    endcase
  endfunction

  // Data mask for right-aligned read data of a given width.
  function automatic logic [63:0] data_mask(input logic [1:0] w);
    case (w)
      2'd0:    data_mask = 64'h0000_0000_0000_00FF;
      2'd1:    data_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    data_mask = 64'h0000_0000_FFFF_FFFF;
      2'd3:    data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic is_aligned(input logic [1:0] w, input logic [2:0] lo);
    case (w)
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = (lo[0] == 1'b0);
      2'd2:    is_aligned = (lo[1:0] == 2'b00);
      2'd3:    is_aligned = (lo == 3'b000);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  lo_q, lo_d;
  logic [1:0]  width_q, width_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [39:0] bus_addr_q, bus_addr_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  bus_wstrb_q, bus_wstrb_d;
  logic [63:0] read_bus_q, read_bus_d;
  logic        task_error_q, task_error_d;

  // Next-state, task latching, timeout counting and completion capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    width_d      = width_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    read_bus_d   = read_bus_q;
    task_error_d = task_error_q;
    case (state_q)
      ST_IDLE: begin
        read_bus_d   = 64'd0;
        task_error_d = 1'b0;
        if (task_valid) begin
          lo_d        = address[2:0];
          width_d     = width_ctr;
          bus_we_d    = rw_ctrl;
          bus_addr_d  = {address[39:3], 3'b000};
          bus_wdata_d = write_bus << {address[2:0], 3'b000};
          bus_wstrb_d = strb_mask(width_ctr) << address[2:0];
          cnt_d       = 16'd0;
          if (is_aligned(width_ctr, address[2:0])) begin
            state_d = ST_REQ;
          end else begin
            // Misaligned tasks complete immediately without touching the bus.
            state_d      = ST_DONE;
            task_error_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A response always wins over the timeout, even in the last cycle.
        if (bus_ack) begin
          state_d      = ST_DONE;
          task_error_d = bus_err;
          if (bus_we_q) begin
            read_bus_d = 64'd0;
          end else begin
            read_bus_d = (bus_rdata >> {lo_q, 3'b000}) & data_mask(width_q);
          end
        end else if (bus_err) begin
          state_d      = ST_DONE;
          task_error_d = 1'b1;
          read_bus_d   = 64'd0;
        end else if (cnt_q == TO_LAST) begin
          state_d      = ST_DONE;
          task_error_d = 1'b1;
          read_bus_d   = 64'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        read_bus_d   = 64'd0;
        task_error_d = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        read_bus_d   = 64'd0;
        task_error_d = 1'b0;
      end
    endcase
    bus_req_d = (state_d == ST_REQ);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      lo_q         <= 3'd0;
      width_q      <= 2'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 40'd0;
      bus_wdata_q  <= 64'd0;
      bus_wstrb_q  <= 8'd0;
      read_bus_q   <= 64'd0;
      task_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      width_q      <= width_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      read_bus_q   <= read_bus_d;
      task_error_q <= task_error_d;
    end
  end

  // In IDLE the ready flag is a combinational handshake with task_valid.
  assign task_ready = (state_q == ST_IDLE) ? ~task_valid : (state_q == ST_DONE);
  assign task_error = task_error_q;
  assign read_bus   = read_bus_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge
// Directed bench for io_bus_bridge with TIMEOUT=4: reset values, aligned
// reads/writes, misalignment, bus error, timeout with late ack, ack in the
// final REQ cycle and reset during REQ. Expected values are hand-computed.
module tb_io_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        task_valid;
  logic [39:0] address;
  logic        rw_ctrl;
  logic [1:0]  width_ctr;
  logic [63:0] write_bus;
  logic [63:0] read_bus;
  logic        task_ready;
  logic        task_error;
  logic        bus_req;
  logic        bus_we;
  logic [39:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  io_bus_bridge #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .task_valid (task_valid),
    .address    (address),
    .rw_ctrl    (rw_ctrl),
    .width_ctr  (width_ctr),
    .write_bus  (write_bus),
    .read_bus   (read_bus),
    .task_ready (task_ready),
    .task_error (task_error),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [39:0] a, input logic rw, input logic [1:0] w,
                       input logic [63:0] wd);
    address    = a;
    rw_ctrl    = rw;
    width_ctr  = w;
    write_bus  = wd;
    task_valid = 1'b1;
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    task_valid = 1'b0;
    address    = 40'd0;
    rw_ctrl    = 1'b0;
    width_ctr  = 2'd0;
    write_bus  = 64'd0;
    bus_ack    = 1'b0;
    bus_rdata  = 64'd0;
    bus_err    = 1'b0;

    // Reset state
    tick;
    check("rst_bus_req", {63'd0, bus_req}, 64'd0);
    check("rst_bus_addr", {24'd0, bus_addr}, 64'd0);
    check("rst_bus_wstrb", {56'd0, bus_wstrb}, 64'd0);
    check("rst_read_bus", read_bus, 64'd0);
    check("rst_ready_idle", {63'd0, task_ready}, 64'd1);
    task_valid = 1'b1;
    #1;
    check("rst_ready_follows_valid", {63'd0, task_ready}, 64'd0);
    task_valid = 1'b0;
    tick;
    rst = 1'b0;

    // Aligned word read, ack after 3 REQ cycles
    start(40'h00_0000_0104, 1'b0, 2'd2, 64'd0);
    tick;
    task_valid = 1'b0;
    address    = 40'h00_0000_0FFF;
    width_ctr  = 2'd0;
    check("wr_req_c1", {63'd0, bus_req}, 64'd1);
    check("wr_addr", {24'd0, bus_addr}, 64'h0000_0000_0100);
    check("wr_strb", {56'd0, bus_wstrb}, 64'h00F0);
    check("wr_ready_busy", {63'd0, task_ready}, 64'd0);
    tick;
    check("wr_addr_stable", {24'd0, bus_addr}, 64'h0000_0000_0100);
    tick;
    check("wr_req_c3", {63'd0, bus_req}, 64'd1);
    bus_ack   = 1'b1;
    bus_rdata = 64'hAABB_CCDD_1122_3344;
    tick;
    bus_ack = 1'b0;
    check("wr_done_ready", {63'd0, task_ready}, 64'd1);
    check("wr_done_err", {63'd0, task_error}, 64'd0);
    check("wr_done_data", read_bus, 64'h0000_0000_AABB_CCDD);
    check("wr_done_req", {63'd0, bus_req}, 64'd0);
    tick;
    check("wr_idle_data", read_bus, 64'd0);

    // Byte write at 0x05, ack in the first REQ cycle
    start(40'h00_0000_0005, 1'b1, 2'd0, 64'h0000_0000_0000_007E);
    tick;
    task_valid = 1'b0;
    check("bw_strb", {56'd0, bus_wstrb}, 64'h0020);
    check("bw_wdata", bus_wdata, 64'h0000_7E00_0000_0000);
    check("bw_we", {63'd0, bus_we}, 64'd1);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    check("bw_done_ready", {63'd0, task_ready}, 64'd1);
    check("bw_done_err", {63'd0, task_error}, 64'd0);
    check("bw_done_data", read_bus, 64'd0);
    tick;

    // Misaligned half read at 0x03
    start(40'h00_0000_0003, 1'b0, 2'd1, 64'd0);
    tick;
    task_valid = 1'b0;
    check("mis_ready", {63'd0, task_ready}, 64'd1);
    check("mis_err", {63'd0, task_error}, 64'd1);
    check("mis_req", {63'd0, bus_req}, 64'd0);
    check("mis_data", read_bus, 64'd0);
    tick;
    check("mis_idle_req", {63'd0, bus_req}, 64'd0);
    check("mis_idle_err", {63'd0, task_error}, 64'd0);

    // Timeout with no response, then a late ack in IDLE
    start(40'h00_0000_0010, 1'b0, 2'd3, 64'd0);
    tick;
    task_valid = 1'b0;
    n = 0;
    while (bus_req && n < 20) begin
      n++;
      tick;
    end
    check("to_req_cycles", 64'(n), 64'd4);
    check("to_done_ready", {63'd0, task_ready}, 64'd1);
    check("to_done_err", {63'd0, task_error}, 64'd1);
    check("to_done_data", read_bus, 64'd0);
    tick;
    tick;
    bus_ack   = 1'b1;
    bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick;
    bus_ack = 1'b0;
    check("late_ack_req", {63'd0, bus_req}, 64'd0);
    check("late_ack_err", {63'd0, task_error}, 64'd0);
    check("late_ack_data", read_bus, 64'd0);
    check("late_ack_ready", {63'd0, task_ready}, 64'd1);

    // Ack in the final REQ cycle wins over timeout
    start(40'h00_0000_0008, 1'b0, 2'd3, 64'd0);
    tick;
    task_valid = 1'b0;
    tick;
    tick;
    tick;
    check("fin_req_c4", {63'd0, bus_req}, 64'd1);
    bus_ack   = 1'b1;
    bus_rdata = 64'h0123_4567_89AB_CDEF;
    tick;
    bus_ack = 1'b0;
    check("fin_err", {63'd0, task_error}, 64'd0);
    check("fin_data", read_bus, 64'h0123_4567_89AB_CDEF);
    tick;

    // Bus error completion
    start(40'h00_0000_0020, 1'b0, 2'd2, 64'd0);
    tick;
    task_valid = 1'b0;
    bus_err    = 1'b1;
    bus_rdata  = 64'h5555_5555_5555_5555;
    tick;
    bus_err = 1'b0;
    check("berr_err", {63'd0, task_error}, 64'd1);
    check("berr_data", read_bus, 64'd0);
    tick;

    // Byte and half reads from the top of the dword
    start(40'h00_0000_0007, 1'b0, 2'd0, 64'd0);
    tick;
    task_valid = 1'b0;
    bus_ack    = 1'b1;
    bus_rdata  = 64'hAB11_2233_4455_6677;
    tick;
    bus_ack = 1'b0;
    check("byte_rd_data", read_bus, 64'h0000_0000_0000_00AB);
    tick;
    start(40'h00_0000_0006, 1'b0, 2'd1, 64'd0);
    tick;
    task_valid = 1'b0;
    check("half_rd_strb", {56'd0, bus_wstrb}, 64'h00C0);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    check("half_rd_data", read_bus, 64'h0000_0000_0000_AB11);
    tick;

    // Reset in the second REQ cycle, then a back-to-back task
    start(40'h00_0000_0040, 1'b1, 2'd2, 64'h0000_0000_1122_3344);
    tick;
    task_valid = 1'b0;
    tick;
    check("rr_req_c2", {63'd0, bus_req}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rr_req_drop", {63'd0, bus_req}, 64'd0);
    check("rr_we_clr", {63'd0, bus_we}, 64'd0);
    check("rr_wdata_clr", bus_wdata, 64'd0);
    tick;
    rst = 1'b0;
    tick;
    check("rr_no_done_err", {63'd0, task_error}, 64'd0);
    check("rr_idle_req", {63'd0, bus_req}, 64'd0);
    start(40'h00_0000_0048, 1'b0, 2'd3, 64'd0);
    tick;
    task_valid = 1'b0;
    check("rr_new_addr", {24'd0, bus_addr}, 64'h0000_0000_0048);
    check("rr_new_strb", {56'd0, bus_wstrb}, 64'h00FF);
    bus_ack   = 1'b1;
    bus_rdata = 64'hFEDC_BA98_7654_3210;
    tick;
    bus_ack = 1'b0;
    check("rr_new_ready", {63'd0, task_ready}, 64'd1);
    check("rr_new_err", {63'd0, task_error}, 64'd0);
    check("rr_new_data", read_bus, 64'hFEDC_BA98_7654_3210);
    tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
